game_fsm_ctrl: RTL and testbench
================================

# game_fsm_ctrl

Clocked, parametrised game controller for the binary-number guessing game. It sequences welcome, ready, guess, lose and win phases from a single player button. It owns the per-level countdown with level-dependent time, a lives counter and best-level tracking. It sits between the debounced button and 1 Hz tick sources and the number generator, comparator and display blocks.

## Interface
Parameters:
- LEVEL_W, 8, width of level and best_level
- TIME_W, 5, width of time_v
- START_TIME, 30, countdown seconds at level 1
- TIME_STEP, 2, seconds removed per level above 1
- MIN_TIME, 3, floor for countdown; must be ≥1 and ≤ START_TIME
- LIVES, 3, lives per game; must be ≥1
- LIVES_W, 2, width of lives
- MAX_LEVEL, 2**LEVEL_W-1, reaching it by a correct guess wins

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- tick_1hz  in  1  one-cycle pulse per second
- guess_b  in  1  debounced button, level
- cmp_r  in  1  comparator says guess equals target; sampled only on a press in GUESS
- state  out  3  WELCOME=0, READY=1, GUESS=2, LOSE=3, WIN=4
- level  out  LEVEL_W  current level, 1-based
- time_v  out  TIME_W  seconds remaining
- time_f  out  1  countdown running (high only in GUESS)
- g_enable  out  1  one-cycle pulse: generate new target number
- lives  out  LIVES_W  lives remaining
- best_level  out  LEVEL_W  highest level reached since reset

## Operation
- Press = rising edge of guess_b: guess_b=1 and registered guess_q=0. guess_q resets to 1, so a button held through reset is ignored until it is released.
- Reset values: state WELCOME, level 1, time_v START_TIME, time_f 0, g_enable 0, lives LIVES, best_level 0.
- WELCOME + press → READY.
- READY + press → GUESS.
  - Load time_v = max(START_TIME − TIME_STEP·(level−1), MIN_TIME).
  - Compute in signed LEVEL_W+TIME_W+2 bits; no underflow wrap.
  - time_f←1, g_enable pulses for one cycle.
- In GUESS, each tick_1hz decrements time_v.
  - A tick with time_v==1 sets time_v←0 and is an expiry.
  - time_v never wraps below 0.
- In GUESS, a press with cmp_r=1 and no expiry is a hit.
  - level ≥ MAX_LEVEL → WIN, level unchanged.
  - Otherwise level←level+1 → READY.
  - best_level←max(best_level, new level).
- A miss is either a press with cmp_r=0, or an expiry.
  - lives←lives−1.
  - If the new lives is 0 → LOSE; otherwise → READY at the same level.
- time_f←0 on any exit from GUESS. time_v holds its last value outside GUESS.
- LOSE + press → READY, level←1, lives←LIVES; best_level kept.
- WIN + press → WELCOME, level←1, lives←LIVES; best_level kept.
- Presses and ticks in states where they are not listed are ignored.

## Timing
- All outputs are registered and update on the clk edge where the press or tick is sampled: 1-cycle latency from input to output.
- g_enable is high for exactly the cycle after the READY→GUESS edge. It is never high twice without another READY→GUESS transition.
- Simultaneous press and expiry in the same cycle: the expiry wins and is a miss, regardless of cmp_r.
- A tick in the same cycle as READY→GUESS is ignored: the full time is loaded.
- rst_n low at any clock edge forces all reset values next cycle, including mid-countdown. g_enable is forced to 0.

## Structure
- Shared package game_pkg holds:
  - the state enum and its encoding (0–4)
  - a function level_time(level) implementing the max(...) rule
- Sub-module level_timer holds the countdown:
  - inputs: load, load_val, run, tick
  - outputs: time_v, expired
- The top contains edge detection, the FSM, and the lives/level/best registers.

## Test plan
- Reset with guess_b held high, then keep it held → state stays 0. Release, then press → state 1.
- Level 1, press in READY → time_v=30, time_f=1, g_enable one-cycle pulse. Same at level 15 (forced) → time_v=3 (30−28 floored). Level 14 → time_v=4.
- GUESS, 30 ticks with no press → time_v 0, lives 3→2, state READY, level unchanged. After two more full expiries → lives 0, state LOSE.
- GUESS with cmp_r=1, press → level 1→2, best_level 2, state READY. Then LOSE, then press → level 1, lives 3, best_level still 2.
- Final tick (time_v=1) and press with cmp_r=1 in the same cycle → treated as a miss: lives decremented, level unchanged.
- LEVEL_W=2 (MAX_LEVEL=3), level 3, correct press → state WIN. Press → WELCOME, level 1. Assert rst_n low mid-GUESS → all outputs at reset values next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: shared state encoding and per-level countdown rule for game_fsm_ctrl
package game_pkg;
  typedef enum logic [2:0] {
    WELCOME = 3'd0,
    READY   = 3'd1,
    GUESS   = 3'd2,
    LOSE    = 3'd3,
    WIN     = 3'd4
  } state_t;
  function automatic int level_time(input int lvl, input int start_t, input int step, input int min_t);
    int t;
    t = start_t - step * (lvl - 1);
    return t < min_t ? min_t : t;
  endfunction
endpackage

// File: rtl/level_timer.sv
// level_timer: countdown (ports: clk, rst_n, load/load_val preset, run/tick decrement, time_v value, expired on the 1->0 tick)
module level_timer #(
  parameter int TIME_W  = 5,
  parameter int RST_VAL = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  input  logic              run,
  input  logic              tick,
  output logic [TIME_W-1:0] time_v,
  output logic              expired
);
  assign expired = run && tick && time_v == TIME_W'(1);
  always_ff @(posedge clk)
    if (!rst_n) time_v <= TIME_W'(RST_VAL);
    else if (load) time_v <= load_val;
    else if (run && tick && time_v != '0) time_v <= time_v - TIME_W'(1);
endmodule

// File: rtl/game_fsm_ctrl.sv
// game_fsm_ctrl: guessing-game sequencer (in: clk, rst_n, tick_1hz, guess_b, cmp_r; out: state, level, time_v, time_f, g_enable, lives, best_level)
module game_fsm_ctrl
  import game_pkg::*;
#(
  parameter int LEVEL_W    = 8,
  parameter int TIME_W     = 5,
  parameter int START_TIME = 30,
  parameter int TIME_STEP  = 2,
  parameter int MIN_TIME   = 3,
  parameter int LIVES      = 3,
  parameter int LIVES_W    = 2,
  parameter int MAX_LEVEL  = 2**LEVEL_W - 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_1hz,
  input  logic               guess_b,
  input  logic               cmp_r,
  output logic [2:0]         state,
  output logic [LEVEL_W-1:0] level,
  output logic [TIME_W-1:0]  time_v,
  output logic               time_f,
  output logic               g_enable,
  output logic [LIVES_W-1:0] lives,
  output logic [LEVEL_W-1:0] best_level
);
  state_t st, st_n;
  logic guess_q, press, load, expired, hit, miss, at_max;
  logic [LEVEL_W-1:0] lvl_n, best_n, lvl_up;
  logic [LIVES_W-1:0] lives_n, lives_dec;
  logic [TIME_W-1:0] load_val;
  assign state     = st;
  assign press     = guess_b && !guess_q;
  assign load      = st == READY && press;
  assign load_val  = TIME_W'(level_time(int'(level), START_TIME, TIME_STEP, MIN_TIME));
  // an expiring tick beats a same-cycle press, whatever the comparator says
  assign hit       = st == GUESS && press && cmp_r && !expired;
  assign miss      = st == GUESS && ((press && !cmp_r) || expired);
  assign at_max    = level >= LEVEL_W'(MAX_LEVEL);
  assign lvl_up    = at_max ? level : level + LEVEL_W'(1);
  assign lives_dec = lives - LIVES_W'(1);
  level_timer #(.TIME_W(TIME_W), .RST_VAL(START_TIME)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .run(st == GUESS), .tick(tick_1hz), .time_v(time_v), .expired(expired)
  );
  always_comb begin
    st_n    = st;
    lvl_n   = level;
    lives_n = lives;
    best_n  = best_level;
    if (press && st == WELCOME) st_n = READY;
    if (load) st_n = GUESS;
    if (hit) begin
      st_n   = at_max ? WIN : READY;
      lvl_n  = lvl_up;
      best_n = lvl_up > best_level ? lvl_up : best_level;
    end
    if (miss) begin
      lives_n = lives_dec;
      st_n    = lives_dec == '0 ? LOSE : READY;
    end
    if (press && (st == LOSE || st == WIN)) begin
      st_n    = st == LOSE ? READY : WELCOME;
      lvl_n   = LEVEL_W'(1);
      lives_n = LIVES_W'(LIVES);
    end
  end
  // guess_q resets high so a button held through reset is not a press
  always_ff @(posedge clk)
    if (!rst_n) begin
      st         <= WELCOME;
      guess_q    <= 1'b1;
      level      <= LEVEL_W'(1);
      lives      <= LIVES_W'(LIVES);
      best_level <= '0;
      time_f     <= 1'b0;
      g_enable   <= 1'b0;
    end else begin
      st         <= st_n;
      guess_q    <= guess_b;
      level      <= lvl_n;
      lives      <= lives_n;
      best_level <= best_n;
      time_f     <= st_n == GUESS;
      g_enable   <= load;
    end
endmodule

// File: tb/tb_game_fsm_ctrl.sv
// tb_game_fsm_ctrl: directed self-checking bench for game_fsm_ctrl (default and LEVEL_W=2 instances)
module tb_game_fsm_ctrl;
  logic clk = 0, rst_n = 0, rst2_n = 0, tick = 0, guess_b = 0, cmp = 0;
  logic [2:0] state, state2;
  logic [7:0] level, best;
  logic [1:0] level2, best2, lives, lives2;
  logic [4:0] time_v, time_v2;
  logic time_f, time_f2, g_en, g_en2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  game_fsm_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick), .guess_b(guess_b), .cmp_r(cmp),
    .state(state), .level(level), .time_v(time_v), .time_f(time_f),
    .g_enable(g_en), .lives(lives), .best_level(best)
  );
  game_fsm_ctrl #(.LEVEL_W(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .tick_1hz(tick), .guess_b(guess_b), .cmp_r(cmp),
    .state(state2), .level(level2), .time_v(time_v2), .time_f(time_f2),
    .g_enable(g_en2), .lives(lives2), .best_level(best2)
  );
  // packed view: state, level, time_v, time_f, g_enable, lives, best_level
  wire [27:0] obs  = {state, level, time_v, time_f, g_en, lives, best};
  wire [15:0] obs2 = {state2, level2, time_v2, time_f2, g_en2, lives2, best2};
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic press();
    cyc();
    guess_b = 1;
    cyc();
    guess_b = 0;
  endtask
  task automatic tick1();
    tick = 1;
    cyc();
    tick = 0;
  endtask
  task automatic test_reset();
    logic [27:0] e;
    guess_b = 1;
    cyc();
    cyc();
    rst_n = 1;
    repeat (3) cyc();
    e = {3'd0, 8'd1, 5'd30, 1'b0, 1'b0, 2'd3, 8'd0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_held got=%h exp=%h", obs, e); end
    guess_b = 0;
    press();
    e = {3'd1, 8'd1, 5'd30, 1'b0, 1'b0, 2'd3, 8'd0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL first_press got=%h exp=%h", obs, e); end
  endtask
  task automatic test_load();
    logic [27:0] e;
    press();
    e = {3'd2, 8'd1, 5'd30, 1'b1, 1'b1, 2'd3, 8'd0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL load_l1 got=%h exp=%h", obs, e); end
    cyc();
    e = {3'd2, 8'd1, 5'd30, 1'b1, 1'b0, 2'd3, 8'd0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL g_pulse got=%h exp=%h", obs, e); end
  endtask
  task automatic test_expiry();
    logic [27:0] e;
    repeat (29) tick1();
    e = {3'd2, 8'd1, 5'd1, 1'b1, 1'b0, 2'd3, 8'd0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL tick_29 got=%h exp=%h", obs, e); end
    tick1();
    e = {3'd1, 8'd1, 5'd0, 1'b0, 1'b0, 2'd2, 8'd0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL expiry1 got=%h exp=%h", obs, e); end
    tick1();
    checks++;
    if (obs !== e) begin errors++; $display("FAIL tick_ignored got=%h exp=%h", obs, e); end
    press();
    repeat (30) tick1();
    e = {3'd1, 8'd1, 5'd0, 1'b0, 1'b0, 2'd1, 8'd0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL expiry2 got=%h exp=%h", obs, e); end
    press();
    repeat (30) tick1();
    e = {3'd3, 8'd1, 5'd0, 1'b0, 1'b0, 2'd0, 8'd0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL lose got=%h exp=%h", obs, e); end
    press();
    e = {3'd1, 8'd1, 5'd0, 1'b0, 1'b0, 2'd3, 8'd0};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL lose_restart got=%h exp=%h", obs, e); end
  endtask
  task automatic test_hit();
    logic [27:0] e;
    press();
    cmp = 1;
    press();
    e = {3'd1, 8'd2, 5'd30, 1'b0, 1'b0, 2'd3, 8'd2};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL hit got=%h exp=%h", obs, e); end
    cmp = 0;
    repeat (3) begin
      press();
      press();
    end
    e = {3'd3, 8'd2, 5'd28, 1'b0, 1'b0, 2'd0, 8'd2};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL miss_lose got=%h exp=%h", obs, e); end
    press();
    e = {3'd1, 8'd1, 5'd28, 1'b0, 1'b0, 2'd3, 8'd2};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL best_kept got=%h exp=%h", obs, e); end
  endtask
  task automatic test_simultaneous();
    logic [27:0] e;
    cyc();
    guess_b = 1;
    tick = 1;
    cyc();
    guess_b = 0;
    tick = 0;
    e = {3'd2, 8'd1, 5'd30, 1'b1, 1'b1, 2'd3, 8'd2};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL tick_on_load got=%h exp=%h", obs, e); end
    repeat (29) tick1();
    cmp = 1;
    tick = 1;
    guess_b = 1;
    cyc();
    tick = 0;
    guess_b = 0;
    cmp = 0;
    e = {3'd1, 8'd1, 5'd0, 1'b0, 1'b0, 2'd2, 8'd2};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL expiry_wins got=%h exp=%h", obs, e); end
  endtask
  task automatic test_level_time();
    logic [27:0] e;
    cmp = 1;
    for (int l = 1; l <= 15; l++) begin
      press();
      if (l == 14) begin
        e = {3'd2, 8'd14, 5'd4, 1'b1, 1'b1, 2'd2, 8'd14};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL lt_14 got=%h exp=%h", obs, e); end
      end
      if (l == 15) begin
        e = {3'd2, 8'd15, 5'd3, 1'b1, 1'b1, 2'd2, 8'd15};
        checks++;
        if (obs !== e) begin errors++; $display("FAIL lt_15 got=%h exp=%h", obs, e); end
      end
      press();
    end
    press();
    e = {3'd2, 8'd16, 5'd3, 1'b1, 1'b1, 2'd2, 8'd16};
    checks++;
    if (obs !== e) begin errors++; $display("FAIL lt_floor got=%h exp=%h", obs, e); end
    cmp = 0;
  endtask
  task automatic test_win();
    logic [15:0] e;
    logic [27:0] e1;
    rst2_n = 1;
    cyc();
    cmp = 1;
    press();
    press();
    press();
    press();
    press();
    press();
    e = {3'd2, 2'd3, 5'd26, 1'b1, 1'b1, 2'd3, 2'd3};
    checks++;
    if (obs2 !== e) begin errors++; $display("FAIL lt_l3 got=%h exp=%h", obs2, e); end
    press();
    e = {3'd4, 2'd3, 5'd26, 1'b0, 1'b0, 2'd3, 2'd3};
    checks++;
    if (obs2 !== e) begin errors++; $display("FAIL win got=%h exp=%h", obs2, e); end
    press();
    e = {3'd0, 2'd1, 5'd26, 1'b0, 1'b0, 2'd3, 2'd3};
    checks++;
    if (obs2 !== e) begin errors++; $display("FAIL win_restart got=%h exp=%h", obs2, e); end
    cmp = 0;
    press();
    press();
    tick1();
    tick1();
    e = {3'd2, 2'd1, 5'd28, 1'b1, 1'b0, 2'd3, 2'd3};
    checks++;
    if (obs2 !== e) begin errors++; $display("FAIL mid_guess got=%h exp=%h", obs2, e); end
    rst2_n = 0;
    rst_n = 0;
    cyc();
    e = {3'd0, 2'd1, 5'd30, 1'b0, 1'b0, 2'd3, 2'd0};
    checks++;
    if (obs2 !== e) begin errors++; $display("FAIL reset_mid got=%h exp=%h", obs2, e); end
    e1 = {3'd0, 8'd1, 5'd30, 1'b0, 1'b0, 2'd3, 8'd0};
    checks++;
    if (obs !== e1) begin errors++; $display("FAIL reset_mid_dut1 got=%h exp=%h", obs, e1); end
  endtask
  initial begin
    test_reset();
    test_load();
    test_expiry();
    test_hit();
    test_simultaneous();
    test_level_time();
    test_win();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
